// File: rtl/sram_if.sv
// Line-store port bundle: one write port and one registered read port.
interface sram_if #(
  parameter int WIDTH    = 64,
  parameter int LOGDEPTH = 9
);
  logic [WIDTH-1:0]    writeData;
  logic [WIDTH-1:0]    readData;
  logic [LOGDEPTH-1:0] writeAddr;
  logic [LOGDEPTH-1:0] readAddr;
  logic                writeEnable;

  modport master (
    output writeData,
    output writeAddr,
    output readAddr,
    output writeEnable,
    input  readData
  );

  modport slave (
    input  writeData,
    input  writeAddr,
    input  readAddr,
    input  writeEnable,
    output readData
  );
endinterface

// File: rtl/sram.sv
// Simple dual-port line store with per-entry valid bits so unwritten lines read as zero.
// Optional write-first collision behaviour: define SRAM_WRITE_BYPASS_EN.
module sram #(
  parameter int WIDTH       = 64,
  parameter int LOGDEPTH    = 9,
  parameter int LOGLINESIZE = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  sram_if.slave  bus
);
  localparam int DEPTH = 1 << LOGDEPTH;

  generate
    if ((WIDTH % (1 << LOGLINESIZE)) != 0) begin : g_bad_width
      $fatal(1, "sram: WIDTH must be a multiple of 2**LOGLINESIZE");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;

`ifdef SRAM_WRITE_BYPASS_EN
  logic collide;
  assign collide = bus.writeEnable && (bus.writeAddr == bus.readAddr);
`endif

  // Data path carries no reset so it maps onto block RAM; zeroing is done by rd_valid_reg.
  always_ff @(posedge clk) begin
    if (rst_n && bus.writeEnable) begin
      mem[bus.writeAddr] <= bus.writeData;
    end
`ifdef SRAM_WRITE_BYPASS_EN
    if (collide) begin
      rd_data_reg <= bus.writeData;
    end else begin
      rd_data_reg <= mem[bus.readAddr];
    end
`else
    rd_data_reg <= mem[bus.readAddr];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (bus.writeEnable) begin
        valid_reg[bus.writeAddr] <= 1'b1;
      end
`ifdef SRAM_WRITE_BYPASS_EN
      rd_valid_reg <= collide ? 1'b1 : valid_reg[bus.readAddr];
`else
      rd_valid_reg <= valid_reg[bus.readAddr];
`endif
    end
  end

  // Both terms are registers, so the output falls to zero the instant reset asserts.
  assign bus.readData = rd_valid_reg ? rd_data_reg : '0;

`ifndef SYNTHESIS
  we_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(bus.writeEnable));
`endif

endmodule

// File: tb/tb_sram.sv
// Randomized self-checking bench for sram against an array-based reference model.
module tb_sram;
  localparam int WIDTH    = 512;
  localparam int LOGDEPTH = 9;
  localparam int DEPTH    = 1 << LOGDEPTH;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  sram_if #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH)) bus ();

  sram #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH), .LOGLINESIZE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what each entry holds and whether it has been written since reset.
  logic [WIDTH-1:0] model_mem [DEPTH];
  bit               model_valid [DEPTH];
  logic [WIDTH-1:0] exp_data = '0;
  bit               chk_en = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  always @(negedge rst_n) begin
    exp_data = '0;
    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit same;
      same = bus.writeEnable && (bus.writeAddr == bus.readAddr);
`ifdef SRAM_WRITE_BYPASS_EN
      if (same) exp_data = bus.writeData;
      else      exp_data = model_valid[bus.readAddr] ? model_mem[bus.readAddr] : '0;
`else
      exp_data = model_valid[bus.readAddr] ? model_mem[bus.readAddr] : '0;
`endif
      if (bus.writeEnable) begin
        model_mem[bus.writeAddr]   = bus.writeData;
        model_valid[bus.writeAddr] = 1'b1;
      end
    end else begin
      exp_data = '0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("model", bus.readData, exp_data);
  end

  function automatic logic [WIDTH-1:0] rnd_line();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Apply one cycle of inputs right after a falling edge; return at the next falling edge.
  task automatic step(input bit we, input int wa, input logic [WIDTH-1:0] wd, input int ra);
    bus.writeEnable = we;
    bus.writeAddr   = LOGDEPTH'(wa);
    bus.writeData   = wd;
    bus.readAddr    = LOGDEPTH'(ra);
    @(negedge clk);
  endtask

  logic [WIDTH-1:0] pat_a5;
  logic [WIDTH-1:0] v_bnd0;
  logic [WIDTH-1:0] v_bnd1;

  initial begin
    pat_a5 = {(WIDTH / 8){8'hA5}};
    bus.writeEnable = 1'b0;
    bus.writeAddr   = '0;
    bus.writeData   = '0;
    bus.readAddr    = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hold", bus.readData, '0);
    step(1'b1, 4, 512'h77, 4);           // write ignored while in reset
    rst_n = 1'b1;

    step(1'b0, 0, '0, 0);   check("reset_rd0", bus.readData, '0);
    step(1'b0, 0, '0, 5);   check("reset_rd5", bus.readData, '0);
    step(1'b0, 0, '0, 511); check("reset_rd511", bus.readData, '0);
    step(1'b0, 0, '0, 4);   check("reset_wr_lost", bus.readData, '0);

    step(1'b1, 7, pat_a5, 8);
    step(1'b0, 0, '0, 7);   check("basic_rd7", bus.readData, pat_a5);
    step(1'b0, 0, '0, 8);   check("basic_rd8", bus.readData, '0);

    step(1'b1, 3, 512'h1234, 7); check("indep_rd7", bus.readData, pat_a5);
    step(1'b0, 0, '0, 3);        check("indep_rd3", bus.readData, 512'h1234);

    step(1'b1, 10, 512'h11, 0);
    step(1'b1, 10, 512'h22, 10);
`ifdef SRAM_WRITE_BYPASS_EN
    check("collide_wf", bus.readData, 512'h22);
`else
    check("collide_rf", bus.readData, 512'h11);
`endif
    step(1'b0, 0, '0, 10); check("collide_next", bus.readData, 512'h22);

    v_bnd0 = rnd_line();
    v_bnd1 = ~v_bnd0;
    step(1'b1, 0, v_bnd0, 1);
    step(1'b1, 511, v_bnd1, 0);  check("bnd_rd0_a", bus.readData, v_bnd0);
    step(1'b0, 0, '0, 511);      check("bnd_rd511", bus.readData, v_bnd1);
    step(1'b0, 0, '0, 0);        check("bnd_rd0_b", bus.readData, v_bnd0);

    for (int i = 0; i < 4; i++) step(1'b1, i, WIDTH'(i + 1), 0);
    step(1'b0, 0, '0, 3);        check("pre_rst_rd3", bus.readData, 512'h4);
    bus.writeEnable = 1'b1; bus.writeAddr = 2; bus.writeData = 512'h55; bus.readAddr = 1;
    #2 rst_n = 1'b0;
    #1 check("async_drop", bus.readData, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.writeEnable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, '0, i);
      check("post_rst_rd", bus.readData, '0);
    end
    step(1'b1, 2, 512'h9, 0);
    step(1'b0, 0, '0, 2);        check("rewrite_rd2", bus.readData, 512'h9);

    // Random traffic on a narrow address window so collisions and rewrites are frequent.
    for (int n = 0; n < 3000; n++) begin
      int  wa;
      int  ra;
      wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rand_async_drop", bus.readData, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
      end
      step(1'($urandom_range(0, 1)), wa, rnd_line(), ra);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram.md
# sram

Simple dual-port (1 read, 1 write) synchronous memory array used as the line store behind the direct-mapped cache. Each entry holds one full cache line; the cache controller supplies line-index addresses only and handles tags and state separately. The block adds a per-entry valid array so that unwritten lines read as zero after reset.

## Interface
- WIDTH, default 64: entry (line) width in bits; the cache instantiates it with its word width × 2^LOGLINESIZE.
- LOGDEPTH, default 9: log2 of the number of entries; depth is 2^LOGDEPTH.
- LOGLINESIZE, default 3: log2 of words per line.
  - Carried for interface compatibility only; no functional effect.
  - Elaboration-time check: WIDTH must be divisible by 2^LOGLINESIZE, otherwise $fatal.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- writeData  input  WIDTH  line to be written.
- readData  output  WIDTH  registered read result.
- writeAddr  input  LOGDEPTH  write entry index.
- readAddr  input  LOGDEPTH  read entry index.
- writeEnable  input  1  write strobe, sampled at the rising edge.

## Operation
- Storage: 2^LOGDEPTH × WIDTH data array plus a 2^LOGDEPTH × 1 valid array.
- Data array is not reset; only readData and the valid array are reset.
- Write: at a rising edge with writeEnable=1, mem[writeAddr] <= writeData and valid[writeAddr] <= 1.
- Read: at every rising edge, readData <= valid[readAddr] ? mem[readAddr] : 0.
  - No read enable; a read occurs every cycle.
- Same-address read and write in one cycle (readAddr == writeAddr, writeEnable=1):
  - Behaviour depends on the macro described under Configuration.
- Different-address read and write in one cycle: fully independent.
- Addresses are exactly LOGDEPTH bits wide, so every index is in range; no wrap or error condition exists.
- X on writeEnable is a user error. Simulation asserts writeEnable is never X or Z while rst_n=1.

## Timing
- Reset (rst_n=0, asynchronous):
  - readData = 0 immediately.
  - All valid bits = 0.
  - Writes are ignored while rst_n=0.
- Reset deassertion is synchronised by the user; the first write is accepted at the first rising edge with rst_n=1.
- Read latency: 1 cycle. Address presented before edge N gives data on readData after edge N, held until edge N+1.
- Write latency: 1 cycle. Data written at edge N is visible to a read addressing it at edge N+1, i.e. on readData after N+1.
- Reset asserted mid-operation:
  - A write at the same edge is lost.
  - Subsequent reads of all entries return 0 until each entry is rewritten.

## Configuration
- Macro: SRAM_WRITE_BYPASS_EN.
- Defined (write-first):
  - A same-cycle read of the address being written returns writeData on readData after that edge.
- Undefined (read-first):
  - A same-cycle read returns the prior contents: mem[readAddr] if valid, else 0.
  - The new data is visible from the next edge.
- In both modes the write itself and the valid update are identical.

## Test plan
- Reset read: hold rst_n=0, release, read addresses 0, 5, 511 -> readData=0 each cycle.
- Basic write/read (LOGDEPTH=9, WIDTH=512):
  - Write 512'hA5…A5 at index 7, then read 7 next cycle -> readData=512'hA5…A5 one cycle after the read edge.
  - Read 8 -> readData=0.
- Independent ports: in one cycle write 0x1234 to index 3 while reading index 7, which holds 0xA5 pattern -> readData = 0xA5 pattern; next cycle read 3 -> 0x1234.
- Collision: index 10 holds 0x11; same cycle write 0x22 to 10 and read 10.
  - With SRAM_WRITE_BYPASS_EN -> 0x22.
  - Without -> 0x11, then 0x22 on the following read.
- Mid-operation reset:
  - Write indices 0–3 with 0x1..0x4.
  - Pulse rst_n low asynchronously between edges -> readData drops to 0 immediately.
  - Reading 0–3 afterwards -> 0.
  - Rewrite index 2 with 0x9 -> reads 0x9.
- Boundary indices: write distinct values to 0 and 511, read back each -> values match, no aliasing between them.
